cke_sched: RTL and testbench

- Produces the clock-enable strobes for the gated MMCM outputs: TX clock, RX rising-edge clock and RX falling-edge clock.
- Runs on clk_sys and keeps emulated time as three time-to-next-event counters.
- Each active cycle it fires the earliest pending event(s) and reports the emulated time step to the channel model.
- RX period is supplied at run time by the CDR loop; TX period is static per run.

---
 rtl/cke_sched_pkg.sv | 30 +++
 rtl/cke_sched_min3.sv | 48 ++++
 rtl/cke_sched.sv | 134 +++++++++++++
 tb/tb_cke_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cke_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cke_sched_pkg
//  Purpose  : Shared widths, minimum periods, event indices and types for the
//             clock-enable scheduler.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cke_sched_pkg;

  // Default widths of periods/counters and of the emulated-time accumulator.
  localparam int PERIOD_WIDTH = 16;
  localparam int TIME_WIDTH   = 32;

  // Smallest legal periods; RX needs 2 so that the half-period is non-zero.
  localparam int TX_PERIOD_MIN = 1;
  localparam int RX_PERIOD_MIN = 2;

  // Bit positions of the three event sources in fire/eligibility vectors.
  typedef enum int unsigned {
    EVT_TX  = 0,
    EVT_RXP = 1,
    EVT_RXN = 2
  } evt_idx_e;

  typedef logic [PERIOD_WIDTH-1:0] period_t;
  typedef logic [TIME_WIDTH-1:0]   time_t;

endpackage : cke_sched_pkg
`default_nettype wire

// File: rtl/cke_sched_min3.sv
`default_nettype none
// ============================================================================
//  Module   : cke_min3
//  Purpose  : Combinational three-input minimum with per-input eligibility.
//             Ineligible inputs never win and never fire. Every eligible input
//             equal to the minimum is flagged, so ties fire together.
//  Ports    : i_val_tx/i_val_rxp/i_val_rxn - candidate values
//             i_elig  - eligibility mask, indexed by evt_idx_e
//             o_min   - minimum over eligible inputs (all-ones if none)
//             o_fire  - per-input "equals minimum" flags, indexed by evt_idx_e
//  Revision : 1.0 - initial release
// ============================================================================
module cke_min3
  import cke_sched_pkg::*;
#(
  parameter int W = PERIOD_WIDTH
) (
  input  logic [W-1:0] i_val_tx,
  input  logic [W-1:0] i_val_rxp,
  input  logic [W-1:0] i_val_rxn,
  input  logic [2:0]   i_elig,
  output logic [W-1:0] o_min,
  output logic [2:0]   o_fire
);

  logic [W-1:0] w_v [3];
  logic [W-1:0] w_min;

  // Ineligible inputs are pushed to all-ones so they cannot undercut a real one.
  always_comb begin
    w_v[EVT_TX]  = i_elig[EVT_TX]  ? i_val_tx  : '1;
    w_v[EVT_RXP] = i_elig[EVT_RXP] ? i_val_rxp : '1;
    w_v[EVT_RXN] = i_elig[EVT_RXN] ? i_val_rxn : '1;
    w_min = w_v[EVT_TX];
    if (w_v[EVT_RXP] < w_min) w_min = w_v[EVT_RXP];
    if (w_v[EVT_RXN] < w_min) w_min = w_v[EVT_RXN];
  end

  assign o_min = w_min;

  // The eligibility term matters: an ineligible all-ones input must not fire
  // even if every eligible counter also happens to sit at all-ones.
  assign o_fire[EVT_TX]  = i_elig[EVT_TX]  && (i_val_tx  == w_min);
  assign o_fire[EVT_RXP] = i_elig[EVT_RXP] && (i_val_rxp == w_min);
  assign o_fire[EVT_RXN] = i_elig[EVT_RXN] && (i_val_rxn == w_min);

endmodule : cke_min3
`default_nettype wire

// File: rtl/cke_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cke_sched
//  Purpose  : Clock-enable scheduler for the gated MMCM outputs (TX, RX rising,
//             RX falling). Emulated time is kept as three time-to-next-event
//             counters; each active cycle the earliest event(s) fire and the
//             emulated time step is reported.
//  Ports    : clk_sys   - system clock
//             rst       - synchronous reset, active-high
//             run       - advance emulated time this cycle
//             tx_period - TX period in units (clamped to >=1)
//             rx_period - RX period from CDR (clamped to >=2), sampled on rx_p
//             cke_tx / cke_rx_p / cke_rx_n - single-cycle enable strobes
//             evt_valid - any strobe high this cycle
//             dt        - emulated time since previous event
//             emu_time  - emulated time of the current event (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module cke_sched
  import cke_sched_pkg::*;
#(
  parameter int PERIOD_WIDTH = cke_sched_pkg::PERIOD_WIDTH,
  parameter int TIME_WIDTH   = cke_sched_pkg::TIME_WIDTH
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic                    run,
  input  logic [PERIOD_WIDTH-1:0] tx_period,
  input  logic [PERIOD_WIDTH-1:0] rx_period,
  output logic                    cke_tx,
  output logic                    cke_rx_p,
  output logic                    cke_rx_n,
  output logic                    evt_valid,
  output logic [PERIOD_WIDTH-1:0] dt,
  output logic [TIME_WIDTH-1:0]   emu_time
);

  localparam logic [PERIOD_WIDTH-1:0] C_TX_MIN = PERIOD_WIDTH'(TX_PERIOD_MIN);
  localparam logic [PERIOD_WIDTH-1:0] C_RX_MIN = PERIOD_WIDTH'(RX_PERIOD_MIN);

  logic [PERIOD_WIDTH-1:0] r_cnt_tx;
  logic [PERIOD_WIDTH-1:0] r_cnt_rxp;
  logic [PERIOD_WIDTH-1:0] r_cnt_rxn;
  logic                    r_rxn_pend;
  logic [TIME_WIDTH-1:0]   r_time_acc;

  logic                    r_cke_tx;
  logic                    r_cke_rx_p;
  logic                    r_cke_rx_n;
  logic                    r_evt_valid;
  logic [PERIOD_WIDTH-1:0] r_dt;
  logic [TIME_WIDTH-1:0]   r_emu_time;

  logic [PERIOD_WIDTH-1:0] w_tx_clamp;
  logic [PERIOD_WIDTH-1:0] w_rx_clamp;
  logic [PERIOD_WIDTH-1:0] w_m;
  logic [2:0]              w_fire;
  logic [2:0]              w_elig;
  logic [TIME_WIDTH-1:0]   w_time_next;

  assign w_tx_clamp = (tx_period < C_TX_MIN) ? C_TX_MIN : tx_period;
  assign w_rx_clamp = (rx_period < C_RX_MIN) ? C_RX_MIN : rx_period;

  // RX_N only competes while a rising edge is waiting for its falling edge,
  // which is what forces strict P/N alternation.
  assign w_elig = {r_rxn_pend, 1'b1, 1'b1};

  cke_min3 #(
    .W (PERIOD_WIDTH)
  ) u_min3 (
    .i_val_tx  (r_cnt_tx),
    .i_val_rxp (r_cnt_rxp),
    .i_val_rxn (r_cnt_rxn),
    .i_elig    (w_elig),
    .o_min     (w_m),
    .o_fire    (w_fire)
  );

  assign w_time_next = r_time_acc + TIME_WIDTH'(w_m);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_cnt_tx    <= '0;
      r_cnt_rxp   <= '0;
      r_cnt_rxn   <= '0;
      r_rxn_pend  <= 1'b0;
      r_time_acc  <= '0;
      r_cke_tx    <= 1'b0;
      r_cke_rx_p  <= 1'b0;
      r_cke_rx_n  <= 1'b0;
      r_evt_valid <= 1'b0;
      r_dt        <= '0;
      r_emu_time  <= '0;
    end else if (run) begin
      r_cke_tx    <= w_fire[EVT_TX];
      r_cke_rx_p  <= w_fire[EVT_RXP];
      r_cke_rx_n  <= w_fire[EVT_RXN];
      r_evt_valid <= 1'b1;
      r_dt        <= w_m;
      r_emu_time  <= w_time_next;
      r_time_acc  <= w_time_next;

      r_cnt_tx  <= w_fire[EVT_TX]  ? w_tx_clamp : (r_cnt_tx  - w_m);
      r_cnt_rxp <= w_fire[EVT_RXP] ? w_rx_clamp : (r_cnt_rxp - w_m);

      // A rising edge reloads the falling-edge countdown with the half period;
      // that load takes precedence over a coincident falling edge.
      if (w_fire[EVT_RXP]) begin
        r_cnt_rxn  <= w_rx_clamp >> 1;
        r_rxn_pend <= 1'b1;
      end else if (w_fire[EVT_RXN]) begin
        r_rxn_pend <= 1'b0;
      end else if (r_rxn_pend) begin
        // Idle falling-edge counter is left alone so it can never underflow.
        r_cnt_rxn <= r_cnt_rxn - w_m;
      end
    end else begin
      r_cke_tx    <= 1'b0;
      r_cke_rx_p  <= 1'b0;
      r_cke_rx_n  <= 1'b0;
      r_evt_valid <= 1'b0;
      r_dt        <= '0;
    end
  end

  assign cke_tx    = r_cke_tx;
  assign cke_rx_p  = r_cke_rx_p;
  assign cke_rx_n  = r_cke_rx_n;
  assign evt_valid = r_evt_valid;
  assign dt        = r_dt;
  assign emu_time  = r_emu_time;

endmodule : cke_sched
`default_nettype wire

// File: tb/tb_cke_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cke_sched
//  Purpose  : Self-checking bench for cke_sched. A reference model tracks the
//             absolute emulated time of each source's next event and derives
//             strobes, dt and emu_time from those.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cke_sched;

  localparam int PW = 16;
  localparam int TW = 17;
  localparam longint unsigned TMASK = (64'd1 << TW) - 1;

  logic          clk_sys = 1'b0;
  logic          rst;
  logic          run;
  logic [PW-1:0] tx_period;
  logic [PW-1:0] rx_period;
  logic          cke_tx;
  logic          cke_rx_p;
  logic          cke_rx_n;
  logic          evt_valid;
  logic [PW-1:0] dt;
  logic [TW-1:0] emu_time;

  cke_sched #(
    .PERIOD_WIDTH (PW),
    .TIME_WIDTH   (TW)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .run       (run),
    .tx_period (tx_period),
    .rx_period (rx_period),
    .cke_tx    (cke_tx),
    .cke_rx_p  (cke_rx_p),
    .cke_rx_n  (cke_rx_n),
    .evt_valid (evt_valid),
    .dt        (dt),
    .emu_time  (emu_time)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: absolute emulated times of the next event of each source.
  longint unsigned m_next_tx, m_next_rxp, m_next_rxn, m_last;
  bit              m_pend;
  logic [2:0]      e_cke;     // {rx_n, rx_p, tx}
  logic            e_evt;
  longint unsigned e_dt;
  longint unsigned e_time;

  function automatic longint unsigned clampv(input int v, input int lo);
    return (v < lo) ? longint'(lo) : longint'(v);
  endfunction

  task automatic model_reset();
    m_next_tx  = 0;
    m_next_rxp = 0;
    m_next_rxn = 0;
    m_last     = 0;
    m_pend     = 0;
    e_cke      = 3'b000;
    e_evt      = 0;
    e_dt       = 0;
    e_time     = 0;
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit rst_v, input bit run_v, input int txp, input int rxp);
    longint unsigned t, c;
    bit f_tx, f_rxp, f_rxn;
    rst       = rst_v;
    run       = run_v;
    tx_period = PW'(txp);
    rx_period = PW'(rxp);
    if (rst_v) begin
      model_reset();
    end else if (run_v) begin
      t = m_next_tx;
      if (m_next_rxp < t) t = m_next_rxp;
      if (m_pend && m_next_rxn < t) t = m_next_rxn;
      f_tx  = (m_next_tx == t);
      f_rxp = (m_next_rxp == t);
      f_rxn = m_pend && (m_next_rxn == t);
      e_cke  = {f_rxn, f_rxp, f_tx};
      e_evt  = 1;
      e_dt   = t - m_last;
      e_time = t & TMASK;
      m_last = t;
      if (f_tx) m_next_tx = t + clampv(txp, 1);
      if (f_rxp) begin
        c          = clampv(rxp, 2);
        m_next_rxp = t + c;
        m_next_rxn = t + c / 2;
        m_pend     = 1;
      end else if (f_rxn) begin
        m_pend = 0;
      end
    end else begin
      e_cke = 3'b000;
      e_evt = 0;
      e_dt  = 0;
    end
    @(posedge clk_sys);
    #1;
    check("cke",       64'({cke_rx_n, cke_rx_p, cke_tx}), 64'(e_cke));
    check("evt_valid", 64'(evt_valid), 64'(e_evt));
    check("dt",        64'(dt), e_dt);
    check("emu_time",  64'(emu_time), e_time);
  endtask

  initial begin
    int   dts [7];
    logic [2:0] ckes [7];
    int   tx_r, rx_r;
    dts  = '{0, 4, 4, 2, 2, 4, 4};
    ckes = '{3'b011, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b101};
    model_reset();
    rst = 1'b1; run = 1'b0; tx_period = '0; rx_period = '0;

    // Reset state.
    step(1, 0, 10, 8);
    step(1, 0, 10, 8);

    // Basic sequence tx=10, rx=8, also against literal expectations.
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 10, 8);
      check("seq_dt",  64'(dt), 64'(dts[i]));
      check("seq_cke", 64'({cke_rx_n, cke_rx_p, cke_tx}), 64'(ckes[i]));
    end
    check("seq_time20", 64'(emu_time), 64'd20);

    // run toggled 1,0,0,1.
    step(1, 0, 10, 8);
    step(0, 1, 10, 8);
    step(0, 0, 10, 8);
    step(0, 0, 10, 8);
    check("idle_hold_time", 64'(emu_time), 64'd0);
    step(0, 1, 10, 8);
    check("resume_dt", 64'(dt), 64'd4);
    for (int i = 0; i < 4; i++) step(0, 1, 10, 8);

    // rx_period change between RX_P events.
    step(1, 0, 10, 8);
    for (int i = 0; i < 3; i++) step(0, 1, 10, 8);   // rx_p at t=8
    for (int i = 0; i < 10; i++) step(0, 1, 10, 12); // later edges use 12

    // Clamping: tx 0 -> 1, rx 1 -> 2.
    step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1);

    // Reset mid-run with an rx_n pending.
    step(1, 0, 10, 8);
    step(0, 1, 10, 8);
    step(1, 1, 10, 8);
    check("rst_cke0", 64'({cke_rx_n, cke_rx_p, cke_tx}), 64'd0);
    step(0, 1, 10, 8);
    check("post_rst_first", 64'({cke_rx_n, cke_rx_p, cke_tx, dt}), {45'd0, 3'b011, 16'd0});
    step(0, 1, 10, 8);

    // Wrap of the 17-bit emulated time with long periods.
    step(1, 0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 8; i++) step(0, 1, 16'hFFFF, 16'hFFFF);

    // Randomised: run gaps, period changes, occasional resets.
    tx_r = 10; rx_r = 8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) tx_r = int'($urandom_range(0, 24));
      if ($urandom_range(0, 9) == 0)  rx_r = int'($urandom_range(0, 24));
      if ($urandom_range(0, 199) == 0) begin
        tx_r = int'($urandom_range(16'hF000, 16'hFFFF));
        rx_r = int'($urandom_range(16'hF000, 16'hFFFF));
      end
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, tx_r, rx_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cke_sched
`default_nettype wire
